// File: rtl/matvec_fifo_loader.sv
// matvec_fifo_loader
// Fetches NUM_ROWS matrix rows plus one vector word from a memory-mapped read
// port and serialises each word, most-significant element first, into its own
// input FIFO of the MAC array. done pulses once the last byte has been written.
// Optional build macro LOADER_CHECKSUM_EN adds a 16-bit running sum of every
// byte written to the FIFOs.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start
// REQ       | mem_read held with mem_address = BASE_ADDR+row until accepted
// WAIT_DATA | read accepted, waiting for mem_readdatavalid
// FILL      | writing the captured word byte by byte into FIFO[row]
// DONE      | one-cycle done pulse, then back to IDLE
module matvec_fifo_loader #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_ROWS   = 8,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic [ADDR_WIDTH-1:0]          mem_address,
    output logic                           mem_read,
    input  logic                           mem_waitrequest,
    input  logic [DATA_WIDTH*NUM_ROWS-1:0] mem_readdata,
    input  logic                           mem_readdatavalid,
    output logic [DATA_WIDTH-1:0]          fifo_data,
    output logic [NUM_ROWS:0]              fifo_wrreq,
    input  logic [NUM_ROWS:0]              fifo_wrfull
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0]                    checksum
`endif
);

    localparam int MW = DATA_WIDTH * NUM_ROWS;
    localparam int RW = $clog2(NUM_ROWS + 1);
    localparam int BW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_DATA,
        FILL,
        DONE
    } state_t;

    state_t                  state_q;
    logic [RW-1:0]           row_q;
    logic [BW-1:0]           byte_q;
    logic [MW-1:0]           shift_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    mem_read_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic                    wr_en;

    // A write happens whenever FILL is active and the target FIFO has room.
    always_comb begin
        fifo_wrreq = '0;
        wr_en      = (state_q == FILL) && !fifo_wrfull[row_q];
        if (wr_en) begin
            fifo_wrreq[row_q] = 1'b1;
        end
    end

    assign fifo_data   = shift_q[MW-1 -: DATA_WIDTH];
    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_read    = mem_read_q;
    assign mem_address = mem_addr_q;

    // Load sequencer: state, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row_q      <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_read_q <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        row_q      <= '0;
                        state_q    <= REQ;
                        busy_q     <= 1'b1;
                        mem_read_q <= 1'b1;
                        mem_addr_q <= BASE_ADDR;
                    end
                end
                REQ: begin
                    if (!mem_waitrequest) begin
                        mem_read_q <= 1'b0;
                        state_q    <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (mem_readdatavalid) begin
                        shift_q <= mem_readdata;
                        byte_q  <= '0;
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (wr_en) begin
                        shift_q <= shift_q << DATA_WIDTH;
                        byte_q  <= byte_q + BW'(1);
                        if (byte_q == BW'(NUM_ROWS - 1)) begin
                            if (row_q == RW'(NUM_ROWS)) begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end else begin
                                row_q      <= row_q + RW'(1);
                                state_q    <= REQ;
                                mem_read_q <= 1'b1;
                                mem_addr_q <= BASE_ADDR + ADDR_WIDTH'(row_q + RW'(1));
                            end
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum_q;

    // Running sum of written bytes, restarted when a load is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_q <= '0;
        end else if (state_q == IDLE && start) begin
            checksum_q <= '0;
        end else if (wr_en) begin
            checksum_q <= checksum_q + 16'(fifo_data);
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: doc/matvec_fifo_loader.md
Name: matvec_fifo_loader

Overview:
- Upstream feeder for the 8x8 matrix-vector MAC array.
- On `start`, reads NUM_ROWS+1 words from a memory-mapped read port:
  - words 0..NUM_ROWS-1 are matrix A rows;
  - word NUM_ROWS is vector B.
- Serialises each word byte-by-byte into its own input FIFO: A rows into FIFOs 0..NUM_ROWS-1, B into FIFO NUM_ROWS.
- Pulses `done` when all FIFOs are loaded, so the controller can begin pre-read and MAC enable.

Parameters:
- DATA_WIDTH, 8, width of one matrix element and of the FIFO data bus.
- NUM_ROWS, 8, matrix rows and columns; memory word = DATA_WIDTH*NUM_ROWS bits.
- ADDR_WIDTH, 32, memory word-address width.
- BASE_ADDR, 0, word address of row 0; row k is at BASE_ADDR+k.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle load request; honoured only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the final byte has been written.
- mem_address  out  ADDR_WIDTH  word address of the current read.
- mem_read  out  1  read request; held until accepted.
- mem_waitrequest  in  1  memory stall; a request is accepted in a cycle with mem_read=1 and mem_waitrequest=0.
- mem_readdata  in  DATA_WIDTH*NUM_ROWS  read data.
- mem_readdatavalid  in  1  mem_readdata is valid this cycle.
- fifo_data  out  DATA_WIDTH  shared write data to all FIFOs.
- fifo_wrreq  out  NUM_ROWS+1  one-hot write strobe; bit k targets FIFO k.
- fifo_wrfull  in  NUM_ROWS+1  full flag of each FIFO.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, row counter=0, byte counter=0, shift register=0;
  - all outputs 0: busy, done, mem_read, mem_address, fifo_wrreq, fifo_data.
- Asserting rst mid-load aborts immediately. No `done` is produced and no further FIFO writes occur. Bytes already written remain in the FIFOs; clearing them is the FIFO's own reset path.
- FSM states: IDLE, REQ, WAIT_DATA, FILL, DONE.
- IDLE:
  - start=1: row:=0, go to REQ.
  - start=0: stay.
- REQ:
  - mem_read=1, mem_address=BASE_ADDR+row, both stable until accepted.
  - On acceptance go to WAIT_DATA.
- WAIT_DATA:
  - mem_read=0.
  - On mem_readdatavalid=1: capture mem_readdata into the shift register, byte counter:=0, go to FILL.
  - mem_readdatavalid is ignored in every other state. The memory guarantees read latency of at least 1 cycle after acceptance.
- FILL:
  - fifo_data = most-significant byte of the shift register (combinational). Element 0 of a row sits in bits [W-1:W-DATA_WIDTH].
  - fifo_wrreq[row] = (state==FILL) & ~fifo_wrfull[row]; all other bits 0.
  - On a write: shift the register left by DATA_WIDTH, byte counter++.
  - If fifo_wrfull[row]=1: stall with no write and no shift. The stall may be arbitrarily long.
  - After the NUM_ROWS-th write of the row:
    - row==NUM_ROWS: go to DONE;
    - otherwise row++, go to REQ.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=1 in REQ, WAIT_DATA, FILL and DONE.
- start while busy=1 is ignored, including in DONE.
- Totals per load:
  - exactly NUM_ROWS+1 memory reads;
  - exactly (NUM_ROWS+1)*NUM_ROWS FIFO writes, NUM_ROWS per FIFO, in row order 0..NUM_ROWS.
- Minimum load time, no stalls and 1-cycle memory latency: (NUM_ROWS+1)*(NUM_ROWS+2)+1 cycles from start to done = 91 for defaults.
- Counter widths: row counter clog2(NUM_ROWS+1) bits; byte counter clog2(NUM_ROWS) bits (1 bit minimum). No wrap occurs within a load.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- When defined:
  - adds output `checksum`, 16 bits, the unsigned sum mod 2^16 of every byte written to any FIFO;
  - cleared to 0 on reset and in the cycle start is accepted;
  - updated on each fifo_wrreq write cycle;
  - held stable after done until the next accepted start.
- When undefined: the port and its adder are absent; all other behaviour is identical.

Test Plan:
- Reset then start: memory holds row k = {8{k+1}} bytes, vector = 0x0102030405060708, 1-cycle latency, no stalls -> 9 reads at addresses 0..8, 8 writes to each FIFO 0..7 (all bytes k+1), FIFO 8 receives 01..08 in order; done pulses at cycle 91 after start; busy drops the cycle after done.
- mem_waitrequest held high 5 cycles on the row-3 read -> mem_address=3 and mem_read stay stable for all 5 cycles; no extra read issued; data order unchanged.
- fifo_wrfull[2]=1 for 4 cycles mid-row-2 -> no fifo_wrreq and fifo_data frozen for those 4 cycles; row 2 still gets exactly 8 bytes, none duplicated or lost.
- start pulsed again during FILL of row 5 -> ignored; total read count stays 9; single done pulse.
- rst asserted during WAIT_DATA of row 4 -> all outputs 0 within the same cycle (async); after release, a new start performs a full 9-read load from address 0.
- With LOADER_CHECKSUM_EN and the first scenario's data -> checksum = 8*(1+2+…+8) + 36 = 324 = 0x0144 after done.
